// File: rtl/mem_arbiter_if.sv
// Signal bundle between the instruction/data requesters, the arbiter and the shared SRAM-like port.
// slave is the arbiter's view; master is the surrounding requesters plus memory.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto one SRAM-like port: data has priority, instruction fetch is
// protected from starvation, and a flushed fetch completes on the bus but is never reported.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner
// ADDR   | mem_req driven from latched fields until mem_addr_ok
// DATA   | waiting for mem_data_ok, then back to IDLE
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_inst_q, owner_inst_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        discard_q, discard_d;
    logic [2:0]  starve_q, starve_d;
    logic        inst_grant, data_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_inst_q <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            wstrb_q      <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            discard_q    <= 1'b0;
            starve_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            discard_q    <= discard_d;
            starve_q     <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        discard_d    = discard_q;
        starve_d     = starve_q;
        inst_grant   = 1'b0;
        data_grant   = 1'b0;

        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'd0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        bus.mem_req      = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_size     = 2'd0;
        bus.mem_wstrb    = 4'd0;
        bus.mem_addr     = 32'd0;
        bus.mem_wdata    = 32'd0;

        case (state_q)
            S_IDLE: begin
                // A flushed fetch is never granted, even once the starvation limit is hit.
                inst_grant = bus.inst_req && !bus.inst_cancel &&
                             (!bus.data_req || (starve_q == STARVE_LIM));
                data_grant = bus.data_req && !inst_grant;
                discard_d  = 1'b0;
                if (inst_grant) begin
                    owner_inst_d = 1'b1;
                    wr_d         = 1'b0;
                    size_d       = 2'd2;
                    wstrb_d      = 4'd0;
                    addr_d       = bus.inst_addr;
                    wdata_d      = 32'd0;
                    starve_d     = 3'd0;
                    state_d      = S_ADDR;
                end else if (data_grant) begin
                    owner_inst_d = 1'b0;
                    wr_d         = bus.data_wr;
                    size_d       = bus.data_size;
                    wstrb_d      = bus.data_wstrb;
                    addr_d       = bus.data_addr;
                    wdata_d      = bus.data_wdata;
                    if (!bus.inst_req)
                        starve_d = 3'd0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + 3'd1;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.mem_req   = 1'b1;
                bus.mem_wr    = wr_q;
                bus.mem_size  = size_q;
                bus.mem_wstrb = wstrb_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (owner_inst_q && bus.inst_cancel)
                    discard_d = 1'b1;
                if (bus.mem_addr_ok) begin
                    if (owner_inst_q)
                        bus.inst_addr_ok = !discard_d;
                    else
                        bus.data_addr_ok = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (owner_inst_q && bus.inst_cancel)
                    discard_d = 1'b1;
                if (bus.mem_data_ok) begin
                    if (owner_inst_q) begin
                        bus.inst_data_ok = !discard_d;
                        bus.inst_rdata   = discard_d ? 32'd0 : bus.mem_rdata;
                    end else begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = bus.mem_rdata;
                    end
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are quiet for the whole reset cycle, not just after the edge.
        if (reset) begin
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = 32'd0;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = 32'd0;
            bus.mem_req      = 1'b0;
            bus.mem_wr       = 1'b0;
            bus.mem_size     = 2'd0;
            bus.mem_wstrb    = 4'd0;
            bus.mem_addr     = 32'd0;
            bus.mem_wdata    = 32'd0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-vector table, hand-written corner sequences and a
// queue-based scoreboard over randomized serial transactions.
module tb_mem_arbiter;
    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h1C00_8000;
    localparam logic [31:0] WD = 32'h1234_5678;
    localparam logic [31:0] RI = 32'h0280_0000;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        icancel;
        logic        dreq;
        logic        dwr;
        logic [3:0]  dwstrb;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        maok;
        logic        mdok;
        logic [31:0] mrdata;
    } in_t;

    typedef struct {
        logic        mreq;
        logic        mwr;
        logic [31:0] maddr;
        logic [3:0]  mwstrb;
        logic [31:0] mwdata;
        logic        iaok;
        logic        idok;
        logic [31:0] irdata;
        logic        daok;
        logic        ddok;
        logic [31:0] drdata;
    } ex_t;

    typedef struct {
        in_t in;
        ex_t ex;
    } vec_t;

    typedef struct {
        logic        is_inst;
        logic [31:0] rdata;
    } sb_t;

    vec_t  vecs[17];
    sb_t   sb_q[$];
    ex_t   z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk1(name, |{bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr,
                     bus.mem_wdata, bus.inst_addr_ok, bus.inst_data_ok, bus.inst_rdata,
                     bus.data_addr_ok, bus.data_data_ok, bus.data_rdata}, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.inst_cancel = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd2;
        bus.data_wstrb  = '0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic reset_dut();
        clr_in();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic drive(input in_t v);
        reset           = v.rst;
        bus.inst_req    = v.ireq;
        bus.inst_addr   = v.iaddr;
        bus.inst_cancel = v.icancel;
        bus.data_req    = v.dreq;
        bus.data_wr     = v.dwr;
        bus.data_size   = 2'd2;
        bus.data_wstrb  = v.dwstrb;
        bus.data_addr   = v.daddr;
        bus.data_wdata  = v.dwdata;
        bus.mem_addr_ok = v.maok;
        bus.mem_data_ok = v.mdok;
        bus.mem_rdata   = v.mrdata;
    endtask

    initial begin
        string       got;
        int          ng;
        logic        pend;
        logic        is_i;
        logic [31:0] a;
        logic [31:0] rd;
        int          astall;
        int          dstall;
        int          phase;
        logic        done;
        sb_t         e;

        z = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
        vecs[0]  = '{'{'0, '1, IA, '0, '0, '0, 4'h0, '0, '0, '0, '0, '0}, z};
        vecs[1]  = '{'{'0, '1, IA, '0, '0, '0, 4'h0, '0, '0, '1, '0, '0},
                     '{'1, '0, IA, 4'h0, '0, '1, '0, '0, '0, '0, '0}};
        vecs[2]  = '{'{'0, '0, '0, '0, '0, '0, 4'h0, '0, '0, '0, '0, '0}, z};
        vecs[3]  = '{'{'0, '0, '0, '0, '0, '0, 4'h0, '0, '0, '0, '1, RI},
                     '{'0, '0, '0, 4'h0, '0, '0, '1, RI, '0, '0, '0}};
        vecs[4]  = '{'{'0, '0, '0, '0, '0, '0, 4'h0, '0, '0, '1, '1, 32'hDEAD_BEEF}, z};
        vecs[5]  = '{'{'0, '1, IA, '0, '1, '1, 4'hF, DA, WD, '0, '0, '0}, z};
        vecs[6]  = '{'{'0, '1, IA, '0, '1, '1, 4'h3, '0, '0, '0, '0, '0},
                     '{'1, '1, DA, 4'hF, WD, '0, '0, '0, '0, '0, '0}};
        vecs[7]  = '{'{'0, '1, IA, '0, '1, '1, 4'hF, DA, WD, '1, '0, '0},
                     '{'1, '1, DA, 4'hF, WD, '0, '0, '0, '1, '0, '0}};
        vecs[8]  = '{'{'0, '1, IA, '1, '0, '0, 4'h0, '0, '0, '1, '0, '0}, z};
        vecs[9]  = '{'{'0, '1, IA, '0, '0, '0, 4'h0, '0, '0, '0, '1, 32'h0BAD_F00D},
                     '{'0, '0, '0, 4'h0, '0, '0, '0, '0, '0, '1, 32'h0BAD_F00D}};
        vecs[10] = '{'{'0, '1, IA, '0, '0, '0, 4'h0, '0, '0, '0, '0, '0}, z};
        vecs[11] = '{'{'0, '1, IA, '0, '0, '0, 4'h0, '0, '0, '1, '0, '0},
                     '{'1, '0, IA, 4'h0, '0, '1, '0, '0, '0, '0, '0}};
        vecs[12] = '{'{'0, '0, '0, '0, '0, '0, 4'h0, '0, '0, '0, '1, 32'h5},
                     '{'0, '0, '0, 4'h0, '0, '0, '1, 32'h5, '0, '0, '0}};
        vecs[13] = '{'{'0, '0, '0, '0, '0, '0, 4'h0, '0, '0, '0, '0, '0}, z};
        vecs[14] = '{'{'0, '0, '0, '0, '1, '0, 4'h0, 32'h40, '0, '0, '0, '0}, z};
        vecs[15] = '{'{'1, '0, '0, '0, '1, '0, 4'h0, 32'h40, '0, '0, '0, '0}, z};
        vecs[16] = '{'{'0, '0, '0, '0, '0, '0, 4'h0, '0, '0, '0, '1, 32'h77}, z};

        // Reset with every request and response input active.
        clr_in();
        reset = 1'b1;
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        next_cycle();
        chk_zero("reset outputs");
        next_cycle();
        clr_in();
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].in);
            #1;
            chk1($sformatf("v%0d mem_req", i), bus.mem_req, vecs[i].ex.mreq);
            chk1($sformatf("v%0d mem_wr", i), bus.mem_wr, vecs[i].ex.mwr);
            chk($sformatf("v%0d mem_size", i), 32'(bus.mem_size), vecs[i].ex.mreq ? 32'd2 : 32'd0);
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].ex.maddr);
            chk($sformatf("v%0d mem_wstrb", i), 32'(bus.mem_wstrb), 32'(vecs[i].ex.mwstrb));
            chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].ex.mwdata);
            chk1($sformatf("v%0d inst_addr_ok", i), bus.inst_addr_ok, vecs[i].ex.iaok);
            chk1($sformatf("v%0d inst_data_ok", i), bus.inst_data_ok, vecs[i].ex.idok);
            chk($sformatf("v%0d inst_rdata", i), bus.inst_rdata, vecs[i].ex.irdata);
            chk1($sformatf("v%0d data_addr_ok", i), bus.data_addr_ok, vecs[i].ex.daok);
            chk1($sformatf("v%0d data_data_ok", i), bus.data_data_ok, vecs[i].ex.ddok);
            chk($sformatf("v%0d data_rdata", i), bus.data_rdata, vecs[i].ex.drdata);
            next_cycle();
        end

        // Starvation: both requesters held high, memory answers as fast as allowed.
        reset_dut();
        got = "";
        ng = 0;
        pend = 1'b0;
        bus.inst_req  = 1'b1;
        bus.inst_addr = IA;
        bus.data_req  = 1'b1;
        bus.data_addr = DA;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            bus.mem_addr_ok = 1'b0;
            bus.mem_data_ok = pend;
            pend = 1'b0;
            #1;
            if (bus.mem_req) bus.mem_addr_ok = 1'b1;
            #1;
            if (bus.inst_addr_ok) begin got = {got, "I"}; ng++; pend = 1'b1; end
            else if (bus.data_addr_ok) begin got = {got, "D"}; ng++; pend = 1'b1; end
            next_cycle();
        end
        checks++;
        if (got != "DDDDID") begin
            errors++;
            $display("FAIL starve_order: got %s expected DDDDID", got);
        end

        // Flush while the fetch is in DATA, then a normal fetch.
        reset_dut();
        bus.inst_req = 1'b1; bus.inst_addr = IA + 32'd4;
        #1; chk_zero("flush grant"); next_cycle();
        bus.mem_addr_ok = 1'b1;
        #1; chk1("flush inst_addr_ok", bus.inst_addr_ok, 1'b1); next_cycle();
        bus.mem_addr_ok = 1'b0; bus.inst_req = 1'b0; bus.inst_cancel = 1'b1;
        #1; chk1("flush mem_req in DATA", bus.mem_req, 1'b0); next_cycle();
        bus.inst_cancel = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        #1; chk1("flush inst_data_ok", bus.inst_data_ok, 1'b0);
        chk("flush inst_rdata", bus.inst_rdata, 32'd0); next_cycle();
        bus.mem_data_ok = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = IA + 32'd8;
        #1; chk1("flush regrant idle", bus.mem_req, 1'b0); next_cycle();
        bus.mem_addr_ok = 1'b1;
        #1; chk1("flush next mem_req", bus.mem_req, 1'b1);
        chk("flush next mem_addr", bus.mem_addr, IA + 32'd8);
        chk1("flush next inst_addr_ok", bus.inst_addr_ok, 1'b1); next_cycle();
        bus.mem_addr_ok = 1'b0; bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h7;
        #1; chk1("flush next inst_data_ok", bus.inst_data_ok, 1'b1);
        chk("flush next inst_rdata", bus.inst_rdata, 32'h7); next_cycle();

        // Cancel in the very cycle of the final mem_data_ok.
        bus.mem_data_ok = 1'b0; bus.inst_req = 1'b1;
        #1; next_cycle();
        bus.mem_addr_ok = 1'b1;
        #1; chk1("samecyc inst_addr_ok", bus.inst_addr_ok, 1'b1); next_cycle();
        bus.mem_addr_ok = 1'b0; bus.inst_req = 1'b0; bus.inst_cancel = 1'b1;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h99;
        #1; chk1("samecyc inst_data_ok", bus.inst_data_ok, 1'b0);
        chk("samecyc inst_rdata", bus.inst_rdata, 32'd0); next_cycle();

        // Cancel during ADDR: request stays up, no responses reach the fetch side.
        bus.mem_data_ok = 1'b0; bus.inst_cancel = 1'b0; bus.inst_req = 1'b1;
        #1; next_cycle();
        bus.inst_cancel = 1'b1;
        #1; chk1("addrcancel mem_req held", bus.mem_req, 1'b1); next_cycle();
        bus.inst_cancel = 1'b0; bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b1;
        #1; chk1("addrcancel mem_req", bus.mem_req, 1'b1);
        chk1("addrcancel inst_addr_ok", bus.inst_addr_ok, 1'b0); next_cycle();
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
        #1; chk1("addrcancel inst_data_ok", bus.inst_data_ok, 1'b0); next_cycle();
        bus.mem_data_ok = 1'b0;
        #1; chk1("addrcancel back idle", bus.mem_req, 1'b0); next_cycle();

        // Reset in the middle of a fetch.
        reset_dut();
        bus.inst_req = 1'b1; bus.inst_addr = IA;
        #1; next_cycle();
        #1; chk1("rstmid mem_req before", bus.mem_req, 1'b1);
        reset = 1'b1;
        #1; chk_zero("rstmid during reset"); next_cycle();
        reset = 1'b0; bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h55;
        #1; chk_zero("rstmid after edge"); next_cycle();
        #1; chk_zero("rstmid late data_ok"); next_cycle();
        bus.mem_data_ok = 1'b0;

        // Address-phase stall: latched request must not track the requester's inputs.
        reset_dut();
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'hF;
        bus.data_addr = DA; bus.data_wdata = WD;
        #1; next_cycle();
        for (int k = 0; k < 5; k++) begin
            bus.data_addr = DA + 32'((k + 1) * 16);
            bus.data_wdata = ~WD;
            #1;
            chk1($sformatf("stall%0d mem_req", k), bus.mem_req, 1'b1);
            chk($sformatf("stall%0d mem_addr", k), bus.mem_addr, DA);
            chk($sformatf("stall%0d mem_wdata", k), bus.mem_wdata, WD);
            chk1($sformatf("stall%0d data_addr_ok", k), bus.data_addr_ok, 1'b0);
            next_cycle();
        end
        bus.mem_addr_ok = 1'b1;
        #1; chk1("stall data_addr_ok", bus.data_addr_ok, 1'b1); next_cycle();
        bus.mem_addr_ok = 1'b0; bus.data_req = 1'b0; bus.mem_data_ok = 1'b1;
        #1; chk1("stall data_data_ok", bus.data_data_ok, 1'b1); next_cycle();
        bus.mem_data_ok = 1'b0;

        // Scoreboard: serial random transactions with random memory stalls.
        reset_dut();
        for (int t = 0; t < 20; t++) begin
            is_i   = 1'($urandom_range(0, 1));
            a      = $urandom;
            rd     = $urandom;
            astall = int'($urandom_range(0, 3));
            dstall = int'($urandom_range(0, 3));
            sb_q.push_back('{is_i, rd});
            bus.inst_req   = is_i;
            bus.inst_addr  = a;
            bus.data_req   = !is_i;
            bus.data_wr    = 1'($urandom_range(0, 1));
            bus.data_wstrb = 4'hF;
            bus.data_addr  = a;
            bus.data_wdata = $urandom;
            phase = 0;
            done  = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                bus.mem_addr_ok = 1'b0;
                bus.mem_data_ok = 1'b0;
                bus.mem_rdata   = '0;
                #1;
                if (phase == 0 && bus.mem_req) begin
                    if (astall == 0) begin
                        chk($sformatf("sb%0d mem_addr", t), bus.mem_addr, a);
                        bus.mem_addr_ok = 1'b1;
                        phase = 1;
                    end else astall--;
                end else if (phase == 1) begin
                    if (dstall == 0) begin
                        bus.mem_data_ok = 1'b1;
                        bus.mem_rdata   = rd;
                        phase = 2;
                    end else dstall--;
                end
                #1;
                if (bus.inst_addr_ok || bus.data_addr_ok) begin
                    chk1($sformatf("sb%0d addr_ok owner", t), bus.inst_addr_ok, is_i);
                    bus.inst_req = 1'b0;
                    bus.data_req = 1'b0;
                end
                if ((bus.inst_data_ok || bus.data_data_ok) && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk1($sformatf("sb%0d data_ok owner", t), bus.inst_data_ok, e.is_inst);
                    chk($sformatf("sb%0d rdata", t),
                        e.is_inst ? bus.inst_rdata : bus.data_rdata, e.rdata);
                    done = 1'b1;
                end
                next_cycle();
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL sb%0d timeout: got no data_ok expected one within 40 cycles", t);
                reset_dut();
                sb_q.delete();
            end
        end
        clr_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while inst_req is pending.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-004 SHALL have ports inst_req in 1, inst_addr in 32, inst_cancel in 1: instruction read requester; inst_cancel is the pipeline flush.
REQ-005 SHALL have ports inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out 32: instruction responses.
REQ-006 SHALL have ports data_req in 1, data_wr in 1, data_size in 2, data_wstrb in 4, data_addr in 32, data_wdata in 32: data requester.
REQ-007 SHALL have ports data_addr_ok out 1, data_data_ok out 1, data_rdata out 32: data responses.
REQ-008 SHALL have ports mem_req out 1, mem_wr out 1, mem_size out 2, mem_wstrb out 4, mem_addr out 32, mem_wdata out 32: shared SRAM-like request port.
REQ-009 SHALL have ports mem_addr_ok in 1, mem_data_ok in 1, mem_rdata in 32: shared-port responses.

Function
REQ-010 SHALL implement an FSM with states IDLE, ADDR and DATA, and allow at most one outstanding transaction.
REQ-011 In IDLE, SHALL grant data if data_req=1, else inst if inst_req=1 and inst_cancel=0, else stay in IDLE.
REQ-012 In IDLE, if inst_req=1 and starve_cnt=STARVE_MAX, SHALL grant inst even if data_req=1.
REQ-013 On a grant, SHALL latch owner, wr, size, wstrb, addr and wdata, and move to ADDR on the next edge.
REQ-014 For an inst grant, SHALL latch wr=0, size=2, wstrb=0 and wdata=0.
REQ-015 SHALL have a 3-bit starve_cnt that increments on a data grant while inst_req=1, saturating at STARVE_MAX.
REQ-016 SHALL clear starve_cnt on any inst grant, and on a data grant while inst_req=0.
REQ-017 In ADDR, SHALL drive mem_req=1 and all mem_* request fields from the latched values only.
REQ-018 SHALL drive mem_req=0 in IDLE and DATA.
REQ-019 In ADDR with mem_addr_ok=1, SHALL pulse the owner's *_addr_ok for that same cycle and move to DATA.
REQ-020 In DATA with mem_data_ok=1, SHALL pulse the owner's *_data_ok for that cycle with *_rdata=mem_rdata, then move to IDLE.
REQ-021 SHALL return write transactions' data_ok exactly as it returns reads.
REQ-022 SHALL ignore mem_data_ok outside DATA and mem_addr_ok outside ADDR.
REQ-023 SHALL hold non-owner *_addr_ok and *_data_ok at 0.
REQ-024 SHALL drive *_rdata to 0 whenever the corresponding data_ok is 0.
REQ-025 Minimum latency SHALL be grant in IDLE (cycle 0), mem_req in cycle 1, data_ok no earlier than cycle 2.
REQ-026 SHALL set a discard flag when inst_cancel=1 while owner=inst in ADDR or DATA.
REQ-027 A discarded transaction SHALL still complete on the shared port, since mem_req is never withdrawn before mem_addr_ok.
REQ-028 A discarded transaction SHALL suppress inst_addr_ok and inst_data_ok for the rest of that transaction.
REQ-029 SHALL clear the discard flag on return to IDLE.
REQ-030 If inst_cancel=1 in the same cycle as the final mem_data_ok, SHALL suppress that inst_data_ok.
REQ-031 SHALL ignore inst_cancel when owner=data.
REQ-032 A new request SHALL be arbitrated in the cycle after DATA completes, with no back-to-back overlap.

Reset
REQ-033 On reset=1 at a clock edge, SHALL enter IDLE and clear owner, discard flag, starve_cnt and all latched fields.
REQ-034 While reset=1, SHALL drive every output to 0.
REQ-035 Reset SHALL take effect mid-transaction and SHALL drop any in-flight response.
REQ-036 After reset, any late mem_data_ok SHALL be ignored because the FSM is in IDLE.

Verification
REQ-037 Inst read: inst_req=1, addr=0x1C000000, mem_addr_ok in cycle 1, mem_data_ok+rdata=0x02800000 in cycle 3 -> inst_addr_ok pulse in cycle 1, inst_data_ok pulse in cycle 3 with rdata=0x02800000.
REQ-038 Conflict: inst_req and data_req (wr=1, addr=0x1C008000, wstrb=0xF, wdata=0x12345678) both high in IDLE -> data granted first; mem_wr=1 with the latched values; inst granted after data_data_ok.
REQ-039 Starvation: data_req held high with inst_req high, STARVE_MAX=4 -> grants are D,D,D,D,I,D...
REQ-040 Flush: inst_cancel=1 while inst is in DATA -> mem_data_ok arrives, inst_data_ok stays 0, FSM returns to IDLE, next inst request is served normally.
REQ-041 Reset mid-op: reset=1 in ADDR with mem_req=1 -> next cycle all outputs 0 and state IDLE; mem_data_ok one cycle later -> no *_data_ok pulse.
REQ-042 Stall: mem_addr_ok held 0 for 5 cycles -> mem_req and mem_addr stay stable and unchanged for all 5 cycles.
